fb_dco_gen: RTL and testbench

Digitally controlled oscillator and feedback divider that generates the DPLL feedback clock `clk_fb`. It is the signal source that the lock detector compares against `clk_ref`. The loop filter writes a frequency control word (FCW) through a load/ack handshake. The block runs a phase accumulator at the system clock, divides the accumulator overflow rate by a programmable ratio, and drives `clk_fb` as a registered square wave with a one-cycle rising-edge strobe. FCW updates take effect only on an accumulator overflow, so the output phase stays continuous.

---
 rtl/fb_dco_if.sv | 38 +++
 rtl/fb_dco_gen.sv | 129 ++++++++++++
 tb/tb_fb_dco_gen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_dco_if.sv
// Control and status bundle between the loop filter and the DCO/feedback divider.
//
// Handshake: fcw_load is a single-cycle request pulse that carries fcw_in in the
// same cycle; the DCO always accepts it, and fcw_ack pulses for exactly one cycle
// on the cycle after the capture.
// There is no back-pressure, and a second load before the first one applies
// replaces it.
// The *_dbg signals expose internal state (accumulator, divider count, pending
// flag) for observation only.
interface fb_dco_if #(
  parameter int ACC_W = 16,
  parameter int DIV_W = 4
);
  logic             en;
  logic [ACC_W-1:0] fcw_in;
  logic             fcw_load;
  logic             fcw_ack;
  logic [DIV_W-1:0] div_n;
  logic             clk_fb;
  logic             fb_rise;
  logic [ACC_W-1:0] fcw_active;
  logic             clamped;
  logic [ACC_W-1:0] acc_dbg;
  logic [DIV_W-1:0] cnt_dbg;
  logic             pend_v_dbg;

  modport master (
    output en, fcw_in, fcw_load, div_n,
    input  fcw_ack, clk_fb, fb_rise, fcw_active, clamped,
           acc_dbg, cnt_dbg, pend_v_dbg
  );

  modport slave (
    input  en, fcw_in, fcw_load, div_n,
    output fcw_ack, clk_fb, fb_rise, fcw_active, clamped,
           acc_dbg, cnt_dbg, pend_v_dbg
  );
endinterface

// File: rtl/fb_dco_gen.sv
// Phase-accumulator DCO with a programmable overflow divider.
// It produces the DPLL feedback clock clk_fb and a rising-edge strobe.
// A new FCW is held pending and swapped in only on an accumulator overflow, so
// the output phase never jumps.
module fb_dco_gen #(
  parameter int               ACC_W     = 16,
  parameter int               DIV_W     = 4,
  parameter logic [ACC_W-1:0] FCW_MIN   = 16'h0010,
  parameter logic [ACC_W-1:0] FCW_MAX   = 16'h8000,
  parameter logic [ACC_W-1:0] FCW_RESET = 16'h0100
) (
  input  logic     clk,
  input  logic     rst_n,
  fb_dco_if.slave  bus
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_active_q, fcw_active_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_fb_q, clk_fb_d;
  logic             rise_q, rise_d;
  logic             ack_q, ack_d;
  logic             clamped_q, clamped_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [DIV_W-1:0] div_lim;
  logic             div_wrap;
  logic [ACC_W-1:0] fcw_lim;
  logic             req_clamped;

  // The extra top bit of the sum is the overflow that clocks the divider.
  assign sum      = {1'b0, acc_q} + {1'b0, fcw_active_q};
  assign carry    = sum[ACC_W];
  // A ratio of 0 behaves as 1.
  // The >= test lets a lowered ratio wrap on the very next carry.
  assign div_lim  = (bus.div_n == '0) ? '0 : bus.div_n - DIV_W'(1);
  assign div_wrap = (cnt_q >= div_lim);

  // Clamp the requested FCW into the legal range and flag when that happened.
  always_comb begin
    fcw_lim     = bus.fcw_in;
    req_clamped = 1'b0;
    if (bus.fcw_in < FCW_MIN) begin
      fcw_lim     = FCW_MIN;
      req_clamped = 1'b1;
    end else if (bus.fcw_in > FCW_MAX) begin
      fcw_lim     = FCW_MAX;
      req_clamped = 1'b1;
    end
  end

  // Next state: accumulate, divide overflows, apply pending FCW, capture loads.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    clk_fb_d     = clk_fb_q;
    rise_d       = 1'b0;
    fcw_active_d = fcw_active_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    ack_d        = 1'b0;
    clamped_d    = clamped_q;

    if (bus.en) begin
      acc_d = sum[ACC_W-1:0];
      if (carry) begin
        if (div_wrap) begin
          cnt_d    = '0;
          clk_fb_d = ~clk_fb_q;
          rise_d   = ~clk_fb_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
    end

    // While stopped there is no phase to protect, so apply without waiting.
    if (pend_v_q && (!bus.en || carry)) begin
      fcw_active_d = pend_q;
      pend_v_d     = 1'b0;
    end

    // A load after the apply above keeps the new request pending.
    if (bus.fcw_load) begin
      pend_d    = fcw_lim;
      pend_v_d  = 1'b1;
      ack_d     = 1'b1;
      clamped_d = req_clamped;
    end
  end

  // State registers; reset discards any pending request without acknowledging it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      fcw_active_q <= FCW_RESET;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      cnt_q        <= '0;
      clk_fb_q     <= 1'b0;
      rise_q       <= 1'b0;
      ack_q        <= 1'b0;
      clamped_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fcw_active_q <= fcw_active_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      cnt_q        <= cnt_d;
      clk_fb_q     <= clk_fb_d;
      rise_q       <= rise_d;
      ack_q        <= ack_d;
      clamped_q    <= clamped_d;
    end
  end

  assign bus.fcw_ack    = ack_q;
  assign bus.clk_fb     = clk_fb_q;
  assign bus.fb_rise    = rise_q;
  assign bus.fcw_active = fcw_active_q;
  assign bus.clamped    = clamped_q;
  assign bus.acc_dbg    = acc_q;
  assign bus.cnt_dbg    = cnt_q;
  assign bus.pend_v_dbg = pend_v_q;

endmodule

// File: tb/tb_fb_dco_gen.sv
// Bench for fb_dco_gen with ACC_W=8, FCW range 4..128, reset FCW 64.
// A phase-total reference model runs alongside the DUT.
// Scripted scenarios add hand-computed literal checks.
module tb_fb_dco_gen;
  localparam int ACC_W = 8;
  localparam int DIV_W = 4;
  localparam int F_MIN = 4;
  localparam int F_MAX = 128;
  localparam int F_RST = 64;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_on = 0;

  fb_dco_if #(.ACC_W(ACC_W), .DIV_W(DIV_W)) bus ();

  fb_dco_gen #(
    .ACC_W(ACC_W), .DIV_W(DIV_W),
    .FCW_MIN(8'd4), .FCW_MAX(8'd128), .FCW_RESET(8'd64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // The phase is kept as an unbounded running total.
  // An overflow is any cycle where the total crosses a multiple of 2^ACC_W.
  // The divider counts overflows since the last clk_fb toggle.
  longint m_phase;
  int     m_fcw;
  int     m_pend[$];
  int     m_ovf;
  bit     m_clk, m_rise, m_ack, m_clamped;

  function automatic int clamp_fcw(int req);
    if (req < F_MIN) return F_MIN;
    if (req > F_MAX) return F_MAX;
    return req;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_p
    bit  c;
    int  ratio;
    int  req;
    if (!rst_n) begin
      m_phase = 0; m_fcw = F_RST; m_pend.delete(); m_ovf = 0;
      m_clk = 0; m_rise = 0; m_ack = 0; m_clamped = 0;
    end else begin
      m_rise = 0;
      c      = 0;
      ratio  = (int'(bus.div_n) == 0) ? 1 : int'(bus.div_n);
      if (bus.en) begin
        c = ((m_phase + m_fcw) >> ACC_W) != (m_phase >> ACC_W);
        m_phase += m_fcw;
        if (c) begin
          m_ovf++;
          if (m_ovf >= ratio) begin
            m_ovf  = 0;
            m_clk  = !m_clk;
            m_rise = m_clk;
          end
        end
      end
      if (m_pend.size() > 0 && (!bus.en || c)) begin
        m_fcw = m_pend[0];
        m_pend.delete();
      end
      m_ack = bus.fcw_load;
      if (bus.fcw_load) begin
        req = int'(bus.fcw_in);
        m_pend.delete();
        m_pend.push_back(clamp_fcw(req));
        m_clamped = (clamp_fcw(req) != req);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare the registered outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("clk_fb",     32'(bus.clk_fb),     32'(m_clk));
      check("fb_rise",    32'(bus.fb_rise),    32'(m_rise));
      check("fcw_ack",    32'(bus.fcw_ack),    32'(m_ack));
      check("clamped",    32'(bus.clamped),    32'(m_clamped));
      check("fcw_active", 32'(bus.fcw_active), 32'(m_fcw));
      check("acc",        32'(bus.acc_dbg),    32'(m_phase % (64'd1 << ACC_W)));
      check("cnt",        32'(bus.cnt_dbg),    32'(m_ovf));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input int val, input int exp_clamped);
    bus.fcw_in   = ACC_W'(val);
    bus.fcw_load = 1'b1;
    tick();
    bus.fcw_load = 1'b0;
    check("load_ack", 32'(bus.fcw_ack), 32'd1);
    check("load_clamped", 32'(bus.clamped), 32'(exp_clamped));
  endtask

  task automatic wait_active(input int exp, input int bound);
    for (int k = 0; k < bound && int'(bus.fcw_active) != exp; k++) tick();
    check("active_applied", 32'(bus.fcw_active), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_rise, second_rise, rises, t0, last_rise, gap;
    bit saw40;
    bit clk_before;
    logic [ACC_W-1:0] acc_before;
    int k;

    rst_n = 1'b0;
    bus.en = 1'b0; bus.fcw_in = '0; bus.fcw_load = 1'b0; bus.div_n = 4'd2;
    repeat (3) tick();
    rst_n = 1'b1;
    chk_on = 1;
    tick();
    check("rst_clk_fb",  32'(bus.clk_fb),     32'd0);
    check("rst_active",  32'(bus.fcw_active), 32'd64);
    check("rst_ack",     32'(bus.fcw_ack),    32'd0);
    check("rst_clamped", 32'(bus.clamped),    32'd0);

    // Free run, div_n=2: first rise after 8 edges, then every 16.
    bus.en = 1'b1;
    first_rise = 0; second_rise = 0; rises = 0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (bus.fb_rise) begin
        rises++;
        if (rises == 1) first_rise = i;
        if (rises == 2) second_rise = i;
      end
    end
    check("first_rise_cycle", 32'(first_rise), 32'd8);
    check("rise_period", 32'(second_rise - first_rise), 32'd16);
    check("rise_count", 32'(rises), 32'd2);

    // Load 32 mid-period: ack next cycle, old FCW until the next carry.
    repeat (3) tick();
    do_load(32, 0);
    check("active_held", 32'(bus.fcw_active), 32'd64);
    wait_active(32, 20);
    rises = 0; last_rise = 0; gap = 0; t0 = 0;
    for (int i = 0; i < 100 && rises < 3; i++) begin
      tick();
      t0++;
      if (bus.fb_rise) begin
        rises++;
        if (rises > 1) gap = t0 - last_rise;
        last_rise = t0;
      end
    end
    check("period_fcw32", 32'(gap), 32'd32);

    // Clamping.
    do_load(200, 1);
    wait_active(128, 300);
    do_load(1, 1);
    wait_active(4, 300);
    do_load(50, 0);
    wait_active(50, 300);

    // Two loads before one carry: only the second applies.
    for (k = 0; k < 20 && int'(bus.acc_dbg) >= 150; k++) tick();
    bus.fcw_in = 8'd40; bus.fcw_load = 1'b1;
    tick();
    check("dbl_ack1", 32'(bus.fcw_ack), 32'd1);
    bus.fcw_in = 8'd48;
    tick();
    bus.fcw_load = 1'b0;
    check("dbl_ack2", 32'(bus.fcw_ack), 32'd1);
    check("dbl_not_yet", 32'(bus.fcw_active), 32'd50);
    saw40 = 0;
    for (k = 0; k < 20 && int'(bus.fcw_active) != 48; k++) begin
      tick();
      if (int'(bus.fcw_active) == 40) saw40 = 1;
    end
    check("dbl_applied", 32'(bus.fcw_active), 32'd48);
    check("dbl_never40", 32'(saw40), 32'd0);

    // div_n=0 and 1 are the same ratio; the model treats both as 1.
    bus.div_n = 4'd0;
    repeat (60) tick();
    bus.div_n = 4'd1;
    repeat (60) tick();

    // Lowering div_n from 8 to 2 with cnt=5 wraps on the next carry.
    bus.div_n = 4'd8;
    for (k = 0; k < 200 && int'(bus.cnt_dbg) != 5; k++) tick();
    check("cnt_reached5", 32'(bus.cnt_dbg), 32'd5);
    bus.div_n  = 4'd2;
    clk_before = bus.clk_fb;
    for (k = 0; k < 20 && int'(bus.cnt_dbg) == 5; k++) tick();
    check("div_dec_wrap_cnt", 32'(bus.cnt_dbg), 32'd0);
    check("div_dec_toggle", 32'(bus.clk_fb), 32'(!clk_before));

    // Randomised run with random ratios and loads.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) bus.div_n = DIV_W'($urandom_range(0, 4));
      bus.fcw_load = ($urandom_range(0, 19) == 0);
      bus.fcw_in   = ACC_W'($urandom_range(0, 255));
      bus.en       = ($urandom_range(0, 9) != 0);
      tick();
    end
    bus.fcw_load = 1'b0;
    bus.en = 1'b1;
    bus.div_n = 4'd2;
    do_load(48, 0);
    wait_active(48, 20);

    // en=0 with a pending load: frozen phase, immediate apply.
    bus.en = 1'b0;
    acc_before = bus.acc_dbg;
    clk_before = bus.clk_fb;
    do_load(100, 0);
    check("frz_active_old", 32'(bus.fcw_active), 32'd48);
    tick();
    check("frz_active_new", 32'(bus.fcw_active), 32'd100);
    check("frz_acc", 32'(bus.acc_dbg), 32'(acc_before));
    check("frz_clk", 32'(bus.clk_fb), 32'(clk_before));
    repeat (3) tick();
    check("frz_acc_hold", 32'(bus.acc_dbg), 32'(acc_before));
    bus.en = 1'b1;
    repeat (20) tick();

    // Reset mid-period with a pending load and another load in flight.
    bus.fcw_in = 8'd20; bus.fcw_load = 1'b1;
    tick();
    bus.fcw_in = 8'd30;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_ack",     32'(bus.fcw_ack),    32'd0);
    check("mrst_active",  32'(bus.fcw_active), 32'd64);
    check("mrst_clk_fb",  32'(bus.clk_fb),     32'd0);
    check("mrst_rise",    32'(bus.fb_rise),    32'd0);
    check("mrst_clamped", 32'(bus.clamped),    32'd0);
    check("mrst_acc",     32'(bus.acc_dbg),    32'd0);
    tick();
    bus.fcw_load = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", 32'(bus.fcw_ack), 32'd0);
    repeat (40) tick();
    check("post_rst_active", 32'(bus.fcw_active), 32'd64);

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
